// File: rtl/irq_controller.sv
// ----------------------------------------------------------------------------
// irq_controller
// Collects 16 asynchronous interrupt lines and selects the lowest-index
// pending, unmasked request. It injects that request into the PC unit only in
// cycles where the front end can take it safely. No further request is
// injected until the service routine returns and a short holdoff has elapsed.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   irq_in[15:0]   asynchronous interrupt requests, rising-edge sensitive
//   hazard         pipeline stall from CPU
//   branch_hazard  branch suppression from CPU
//   p_cache_miss   program cache miss in progress
//   branch_active  jmp/call/ret/taken-brx resolving this cycle
//   reti           one-cycle return-from-interrupt pulse from decoder
//   interrupt      one-cycle request to PC (combinational)
//   int_addr[3:0]  latched vector index; PC jumps to {int_addr,0}
//   cfg_we         configuration write strobe
//   cfg_addr[1:0]  0 MASK, 1 PENDING (W1C), 2 CTRL (bit0 GIE), 3 STATUS (RO)
//   cfg_wdata      configuration write data
//   cfg_rdata      configuration read data, combinational from cfg_addr
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | nothing armed; arm on the next valid candidate
// ST_ARMED   | id latched; wait for a safe cycle, abort if request vanishes
// ST_SERVICE | handler running; wait for reti
// ST_HOLD    | post-reti holdoff so the return target can be fetched
// ----------------------------------------------------------------------------
module irq_controller #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] irq_in,
   input  logic        hazard,
   input  logic        branch_hazard,
   input  logic        p_cache_miss,
   input  logic        branch_active,
   input  logic        reti,
   output logic        interrupt,
   output logic [3:0]  int_addr,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [15:0] cfg_rdata
);

   localparam int CW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_SERVICE,
      ST_HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     sync_q [SYNC_STAGES];
   logic [15:0]     irq_prev_q;
   logic [15:0]     irq_rise;
   logic [15:0]     mask_q;
   logic [15:0]     pending_q, pending_d;
   logic            gie_q;
   logic [15:0]     cand;
   logic [3:0]      cand_id;
   logic            valid;
   logic            still_valid;
   logic            safe;
   logic            arm;
   logic            fire;
   logic [15:0]     w1c;

   // input synchronizers and edge detect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         irq_prev_q <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         irq_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign irq_rise = sync_q[SYNC_STAGES-1] & ~irq_prev_q;

   // lowest index wins: scan downward so the last hit is the lowest set bit
   assign cand = pending_q & mask_q;
   always_comb begin
      cand_id = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (cand[i]) cand_id = 4'(i);
      end
   end

   assign valid       = gie_q & (|cand);
   assign still_valid = gie_q & mask_q[int_addr] & pending_q[int_addr];
   assign safe        = ~hazard & ~branch_hazard & ~p_cache_miss & ~branch_active;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      arm     = 1'b0;
      fire    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (valid) begin
               arm     = 1'b1;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!still_valid) begin
               state_d = ST_IDLE;
            end else if (safe) begin
               fire    = 1'b1;
               state_d = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (reti) begin
               if (HOLDOFF == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = CW'(HOLDOFF);
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // leave as the count reaches zero, giving exactly HOLDOFF cycles here
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign interrupt = fire;

   // pending: W1C first, then edge set, then the fire clear overrides both
   assign w1c = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 16'h0000;

   always_comb begin
      pending_d = (pending_q & ~w1c) | irq_rise;
      if (fire) pending_d[int_addr] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q    <= '0;
         gie_q     <= 1'b0;
         pending_q <= '0;
         int_addr  <= '0;
      end else begin
         pending_q <= pending_d;
         if (arm) int_addr <= cand_id;
         if (cfg_we && cfg_addr == 2'd0) mask_q <= cfg_wdata;
         if (cfg_we && cfg_addr == 2'd2) gie_q  <= cfg_wdata[0];
      end
   end

   always_comb begin
      cfg_rdata = 16'h0000;
      unique case (cfg_addr)
         2'd0: cfg_rdata = mask_q;
         2'd1: cfg_rdata = pending_q;
         2'd2: cfg_rdata = {15'h0000, gie_q};
         2'd3: cfg_rdata = {8'h00, int_addr, 2'b00,
                            state_q == ST_ARMED, state_q == ST_SERVICE};
         default: cfg_rdata = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// ----------------------------------------------------------------------------
// tb_irq_controller
// Directed scenarios plus a randomized phase, all checked cycle by cycle
// against a behavioural model of the controller kept in this bench.
// ----------------------------------------------------------------------------
module tb_irq_controller;

   localparam int SS = 2;
   localparam int HO = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] irq_in = '0;
   logic        hazard = 0, branch_hazard = 0, p_cache_miss = 0, branch_active = 0;
   logic        reti = 0;
   logic        interrupt;
   logic [3:0]  int_addr;
   logic        cfg_we = 0;
   logic [1:0]  cfg_addr = '0;
   logic [15:0] cfg_wdata = '0;
   logic [15:0] cfg_rdata;

   irq_controller #(.SYNC_STAGES(SS), .HOLDOFF(HO)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .hazard(hazard),
      .branch_hazard(branch_hazard), .p_cache_miss(p_cache_miss),
      .branch_active(branch_active), .reti(reti), .interrupt(interrupt),
      .int_addr(int_addr), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int unsigned vec_q[$];
   int vec_cyc_q[$];
   logic [15:0] obs_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_mask, m_pend;
   logic        m_gie;
   logic [3:0]  m_id;
   bit          m_armed, m_serv;
   int          m_hold;
   logic [15:0] hist [SS+1];   // hist[0] = newest sampled irq_in

   function automatic bit m_safe();
      return !(hazard || branch_hazard || p_cache_miss || branch_active);
   endfunction

   function automatic bit m_still();
      return m_gie && m_mask[m_id] && m_pend[m_id];
   endfunction

   function automatic bit m_fire();
      return m_armed && m_still() && m_safe();
   endfunction

   function automatic bit m_idle();
      return !m_armed && !m_serv && m_hold == 0;
   endfunction

   function automatic logic [15:0] m_rdata(input logic [1:0] a);
      case (a)
         2'd0: return m_mask;
         2'd1: return m_pend;
         2'd2: return {15'h0, m_gie};
         default: return {8'h00, m_id, 2'b00, m_armed, m_serv};
      endcase
   endfunction

   task automatic m_reset();
      m_mask = '0; m_pend = '0; m_gie = 0; m_id = '0;
      m_armed = 0; m_serv = 0; m_hold = 0;
      for (int i = 0; i <= SS; i++) hist[i] = '0;
   endtask

   task automatic m_step();
      logic [15:0] rise, np, cand;
      bit f, still, sf;
      if (!rst) begin
         m_reset();
         return;
      end
      rise = hist[SS-1] & ~hist[SS];
      for (int i = SS; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = irq_in;
      f = m_fire(); still = m_still(); sf = m_safe();
      cand = m_pend & m_mask;
      np = m_pend;
      if (cfg_we && cfg_addr == 2'd1) np = np & ~cfg_wdata;
      np = np | rise;
      if (f) np[m_id] = 1'b0;
      if (m_armed) begin
         if (!still) m_armed = 0;
         else if (sf) begin m_armed = 0; m_serv = 1; end
      end else if (m_serv) begin
         if (reti) begin m_serv = 0; m_hold = HO; end
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (m_gie && cand != 0) begin
         for (int i = 15; i >= 0; i--) if (cand[i]) m_id = 4'(i);
         m_armed = 1;
      end
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
      if (cfg_we && cfg_addr == 2'd2) m_gie = cfg_wdata[0];
      m_pend = np;
   endtask

   // ---------------- cycle driver ----------------
   // Called just after a falling edge with this cycle's inputs already set.
   task automatic run_cycle();
      #1;
      chk("interrupt", interrupt, m_fire());
      chk("int_addr", int_addr, m_id);
      chk("rdata", cfg_rdata, m_rdata(cfg_addr));
      obs_rdata = cfg_rdata;
      if (interrupt === 1'b1) begin
         vec_q.push_back(int_addr);
         vec_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      m_step();
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) run_cycle();
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      run_cycle();
      cfg_we = 0;
   endtask

   task automatic set_hz(input int h, input logic v);
      case (h)
         0: hazard = v;
         1: p_cache_miss = v;
         2: branch_hazard = v;
         default: branch_active = v;
      endcase
   endtask

   // return to idle with nothing outstanding, answering reti when in service
   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (m_idle() && (m_pend & m_mask) == 0) break;
         reti = m_serv;
         run_cycle();
         reti = 0;
      end
      chk("drain_done", m_idle(), 1);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, pend_lat, n0, c_r;
      m_reset();
      @(negedge clk);

      // reset state
      for (int a = 0; a < 4; a++) begin
         cfg_addr = 2'(a);
         run_cycle();
         chk("reset_reg", obs_rdata, 0);
      end
      rst = 1;
      run(2);

      // single request on line 0, pending latency and one-shot pulse
      wr(2'd0, 16'h0001);
      wr(2'd2, 16'h0001);
      cfg_addr = 2'd1;
      n0 = vec_q.size();
      irq_in = 16'h0001;
      c0 = cyc;
      pend_lat = -1;
      for (int k = 0; k < 12; k++) begin
         if (k == 2) irq_in = 16'h0000;
         run_cycle();
         if (pend_lat < 0 && obs_rdata[0]) pend_lat = cyc - 1 - c0;
      end
      chk("pend_latency", pend_lat, SS + 1);
      chk("irq0_count", vec_q.size() - n0, 1);
      if (vec_q.size() > n0) chk("irq0_vector", vec_q[n0], 0);
      chk("irq0_pend_cleared", obs_rdata, 16'h0000);
      cfg_addr = 2'd3;
      run_cycle();
      chk("status_in_service", obs_rdata[0], 1);
      drain();

      // simultaneous 5 and 9
      wr(2'd0, 16'hFFFF);
      n0 = vec_q.size();
      irq_in = 16'h0220;
      run(2);
      irq_in = 16'h0000;
      for (int k = 0; k < 60 && vec_q.size() < n0 + 2; k++) begin
         reti = m_serv;
         run_cycle();
         reti = 0;
      end
      chk("prio_count", vec_q.size() - n0, 2);
      if (vec_q.size() >= n0 + 2) begin
         chk("prio_first", vec_q[n0], 5);
         chk("prio_second", vec_q[n0+1], 9);
      end
      drain();

      // stall on each unsafe input individually
      for (int h = 0; h < 4; h++) begin
         set_hz(h, 1);
         cfg_addr = 2'd3;
         n0 = vec_q.size();
         irq_in = 16'h0008;
         run(2);
         irq_in = 16'h0000;
         run(15);
         chk("stall_armed_bit", obs_rdata[1], 1);
         chk("stall_no_irq", vec_q.size() - n0, 0);
         set_hz(h, 0);
         run_cycle();
         chk("stall_release_irq", vec_q.size() - n0, 1);
         if (vec_q.size() > n0) chk("stall_vector", vec_q[n0], 3);
         drain();
      end

      // abort by W1C while armed and stalled
      hazard = 1;
      n0 = vec_q.size();
      irq_in = 16'h0008;
      run(2);
      irq_in = 16'h0000;
      run(5);
      wr(2'd1, 16'h0008);
      cfg_addr = 2'd1;
      run(3);
      chk("abort_pending", obs_rdata, 16'h0000);
      cfg_addr = 2'd3;
      run_cycle();
      chk("abort_state", obs_rdata[1:0], 0);
      hazard = 0;
      run(4);
      chk("abort_no_irq", vec_q.size() - n0, 0);

      // no nesting; holdoff after reti
      irq_in = 16'h0001;
      for (int k = 0; k < 20 && !m_serv; k++) run_cycle();
      chk("svc_reached", m_serv, 1);
      irq_in = 16'h0004;
      run(2);
      irq_in = 16'h0000;
      n0 = vec_q.size();
      cfg_addr = 2'd1;
      run(20);
      chk("nest_pending", obs_rdata, 16'h0004);
      chk("nest_no_irq", vec_q.size() - n0, 0);
      reti = 1;
      c_r = cyc;
      run_cycle();
      reti = 0;
      for (int k = 0; k < 20 && vec_q.size() == n0; k++) run_cycle();
      chk("post_reti_irq", vec_q.size() - n0, 1);
      if (vec_q.size() > n0) begin
         chk("post_reti_vector", vec_q[n0], 2);
         chk("holdoff_gap", (vec_cyc_q[n0] - c_r) >= HO + 2, 1);
      end
      drain();

      // randomized phase
      for (int k = 0; k < 3000; k++) begin
         irq_in        = 16'($urandom & $urandom & $urandom);
         hazard        = ($urandom_range(0, 3) == 0);
         branch_hazard = ($urandom_range(0, 5) == 0);
         p_cache_miss  = ($urandom_range(0, 5) == 0);
         branch_active = ($urandom_range(0, 5) == 0);
         reti          = ($urandom_range(0, 5) == 0);
         cfg_addr      = 2'($urandom_range(0, 3));
         cfg_we        = ($urandom_range(0, 7) == 0);
         cfg_wdata     = 16'($urandom);
         if (cfg_addr == 2'd2) cfg_wdata[0] = ($urandom_range(0, 3) != 0);
         run_cycle();
      end
      irq_in = '0; hazard = 0; branch_hazard = 0; p_cache_miss = 0;
      branch_active = 0; reti = 0; cfg_we = 0;

      // asynchronous reset while armed and about to fire
      wr(2'd2, 16'h0000);
      drain();
      wr(2'd1, 16'hFFFF);
      wr(2'd0, 16'hFFFF);
      wr(2'd2, 16'h0001);
      hazard = 1;
      irq_in = 16'h0008;
      run(2);
      irq_in = 16'h0000;
      run(6);
      hazard = 0;
      #1;
      chk("pre_rst_fire", interrupt, 1);
      rst = 0;
      #1;
      chk("rst_async_int", interrupt, 0);
      m_reset();
      run(2);
      rst = 1;
      for (int a = 0; a < 4; a++) begin
         cfg_addr = 2'(a);
         run_cycle();
         chk("post_rst_reg", obs_rdata, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
